// File: rtl/conv_pkg.sv
// conv_pkg: shared types and Q-format helpers for the streaming convolution core.
//   state_t  - frame FSM encoding {IDLE, RUN, DRAIN}
//   ONE      - 1.0 in the default Q16.16 format
//   clog2_f  - ceil(log2(n)), used to size the accumulator headroom
//   sat_s    - clamp a wide signed value to a w-bit signed range
package conv_pkg;

    localparam int          FRAC_DEF = 16;
    localparam logic [31:0] ONE      = 32'(1) << FRAC_DEF;

    // Wide enough for a 2*DW + clog2(K*K) + 1 intermediate at any sensible DW.
    localparam int SW = 128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int clog2_f(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic logic signed [SW-1:0] sat_s(input logic signed [SW-1:0] x,
                                                   input int                    w);
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = (SW'(1) <<< (w - 1)) - SW'(1);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one image row of delay. Shifts in din whenever en is high and
// presents the word written DEPTH enables ago on dout, i.e. the pixel directly
// above the one currently on din.
//   clk  - rising-edge clock
//   en   - shift enable (one accepted pixel)
//   din  - pixel in
//   dout - pixel from the previous row, same column
module conv_line_buf #(
    parameter int DEPTH = 12,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; a row is always fully rewritten before the
    // window logic treats it as valid, so clearing it would only add reset fan-out.
    // NOTE: non-blocking assignments keep every stage reading its neighbour's
    // pre-edge value, which is what makes this a shift register.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK valid-mode 2-D convolution on signed fixed point.
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   input_port   - pixel in raster order, qualified by valid (0 = bubble)
//   bias         - added to every result, held stable over a frame
//   k_load/k_data- kernel write port, row-major, accepted only while IDLE
//   output_port  - result word, qualified by invalid=0
//   finish       - pulses with the last result of a frame
//   k_err        - pulses when a kernel write is dropped
// Result for a pixel accepted in cycle t appears in cycle t+2.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DW    = 32,
    parameter int FRAC  = 16,
    parameter int IMG_W = 12,
    parameter int IMG_H = 12,
    parameter int K     = 3,
    parameter int RELU  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] input_port,
    input  logic          valid,
    input  logic [DW-1:0] bias,
    input  logic          k_load,
    input  logic [DW-1:0] k_data,
    output logic [DW-1:0] output_port,
    output logic          invalid,
    output logic          finish,
    output logic          k_err
);

    localparam int NK = K * K;
    localparam int PW = 2 * DW;
    localparam int AW = PW + clog2_f(NK);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [KW-1:0]        k_idx_q;
    logic signed [DW-1:0] w_q    [NK];
    logic signed [DW-1:0] live   [K][K];
    logic signed [PW-1:0] prod_q [NK];
    logic                 s1_vld_q, s1_last_q;
    logic                 k_wr, k_drop;

    logic last_px, win_live;
    assign last_px  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign win_live = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    // Window: K-1 registered columns plus a fresh column built from the current
    // pixel and the line-buffer taps, so the products can register in the same
    // cycle the pixel is accepted. Row 0 is the oldest image row.
    if (K > 1) begin : g_win
        logic [DW-1:0]        lb_in  [K-1];
        logic [DW-1:0]        lb_out [K-1];
        logic signed [DW-1:0] fresh  [K];
        logic signed [DW-1:0] win_q  [K][K-1];

        for (genvar j = 0; j < K - 1; j++) begin : g_lb
            conv_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb (
                .clk  (clk),
                .en   (valid),
                .din  (lb_in[j]),
                .dout (lb_out[j])
            );
        end

        always_comb begin
            lb_in[0] = input_port;
            for (int j = 1; j < K - 1; j++) lb_in[j] = lb_out[j-1];
            for (int r = 0; r < K - 1; r++) fresh[r] = lb_out[K-2-r];
            fresh[K-1] = input_port;
        end

        always_ff @(posedge clk) begin
            if (valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 2; c++) win_q[r][c] <= win_q[r][c+1];
                    win_q[r][K-2] <= fresh[r];
                end
            end
        end

        always_comb begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) live[r][c] = win_q[r][c];
                live[r][K-1] = fresh[r];
            end
        end
    end else begin : g_one
        always_comb live[0][0] = input_port;
    end

    // Frame FSM and kernel-port arbitration. A pixel arriving in DRAIN starts
    // the next frame immediately, so DRAIN only falls back to IDLE when the
    // finish pulse goes out with no new frame under way.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state_q;
        k_wr    = 1'b0;
        k_drop  = 1'b0;
        unique case (state_q)
            IDLE:    if (valid) state_d = last_px ? DRAIN : RUN;
            RUN:     if (valid && last_px) state_d = DRAIN;
            DRAIN:   if (valid) state_d = last_px ? DRAIN : RUN;
                     else if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (k_load) begin
            if (state_q == IDLE && !valid) k_wr   = 1'b1;
            else                           k_drop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            k_idx_q <= '0;
            k_err   <= 1'b0;
            for (int i = 0; i < NK; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_err   <= k_drop;
            if (valid) begin
                if (col_q == CW'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (k_wr) begin
                w_q[k_idx_q] <= k_data;
                k_idx_q      <= (k_idx_q == KW'(NK - 1)) ? '0 : k_idx_q + KW'(1);
            end
        end
    end

    // S1: full-precision products of the live window.
    always_ff @(posedge clk) begin
        if (valid && win_live)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    prod_q[r*K+c] <= PW'(live[r][c]) * PW'(w_q[r*K+c]);
    end

    // S2 combinational part: sum, floor-shift back to Q format, bias, clamp.
    logic signed [AW-1:0] sum, sum_sh;
    logic signed [AW:0]   biased;
    logic signed [DW-1:0] sat_v, res;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NK; i++) sum = sum + AW'(prod_q[i]);
        sum_sh = sum >>> FRAC;
        biased = (AW+1)'(sum_sh) + (AW+1)'($signed(bias));
        sat_v  = DW'(sat_s(SW'(biased), DW));
        res    = (RELU != 0 && sat_v[DW-1]) ? '0 : sat_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            invalid     <= 1'b1;
            finish      <= 1'b0;
            output_port <= '0;
        end else begin
            s1_vld_q  <= valid && win_live;
            s1_last_q <= valid && win_live && last_px;
            invalid   <= !s1_vld_q;
            finish    <= s1_last_q;
            if (s1_vld_q) output_port <= res;
        end
    end

endmodule
